uart_tx_fifo: RTL and testbench

Byte buffer and transmit sequencer sitting directly upstream of the `UART` block's transmit side. It accepts bytes from a producer at system clock rate, stores them in a circular FIFO, and hands them one at a time to the UART via the `Tx_en`/`Din`/`Tx_done` handshake. It holds each byte until the UART reports the frame complete. This decouples bursty producers from the roughly 1.04 ms-per-byte line rate at 9600 baud and 100 MHz.

---
 rtl/uart_tx_fifo_if.sv | 45 ++++
 rtl/uart_tx_fifo.sv | 146 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: producer write port plus the UART transmit handshake
// (Tx_en / Din / Tx_done) for uart_tx_fifo.
// Optional feature macro: UART_TX_FIFO_OVF_EN adds ovf_clr / overflow.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
);
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        full;
  logic        empty;
  logic [AW:0] level;
  logic        busy;
  logic        Tx_en;
  logic [7:0]  Din;
  logic        Tx_done;
`ifdef UART_TX_FIFO_OVF_EN
  logic        ovf_clr;
  logic        overflow;

  // Block side: consumes writes and Tx_done, drives status and the UART request.
  modport slave (
    input  wr_en, wr_data, Tx_done, ovf_clr,
    output full, empty, level, busy, Tx_en, Din, overflow
  );

  // Producer/UART side.
  modport master (
    output wr_en, wr_data, Tx_done, ovf_clr,
    input  full, empty, level, busy, Tx_en, Din, overflow
  );
`else
  // Block side: consumes writes and Tx_done, drives status and the UART request.
  modport slave (
    input  wr_en, wr_data, Tx_done,
    output full, empty, level, busy, Tx_en, Din
  );

  // Producer/UART side.
  modport master (
    output wr_en, wr_data, Tx_done,
    input  full, empty, level, busy, Tx_en, Din
  );
`endif
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO feeding a UART transmitter one byte at a
// time through a Tx_en/Din/Tx_done handshake. Each byte is held on Din until
// the UART reports the frame complete.
// Optional feature macro: UART_TX_FIFO_OVF_EN (sticky overflow flag with clear).
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_REL   = 2'd3
  } state_t;

  localparam logic [AW:0] LP_FULL_CNT = (AW+1)'(DEPTH);

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0] r_cnt;
  logic [7:0]  r_din;
  logic        w_full;
  logic        w_empty;
  logic        w_wr_acc;
  logic        w_pop;
  logic        w_tx_en;

  // Full/empty come from the registered count, so a write in the same cycle
  // as a pop is still refused when the FIFO was full going into that cycle.
  assign w_full   = (r_cnt == LP_FULL_CNT);
  assign w_empty  = (r_cnt == '0);
  assign w_wr_acc = bus.wr_en && !w_full;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and outputs; START waits for Tx_done low so a level left
  // high by the previous frame is not mistaken for completion of this one.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_tx_en      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        w_tx_en = 1'b1;
        if (!bus.Tx_done) begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        w_tx_en = 1'b1;
        if (bus.Tx_done) begin
          w_state_next = S_REL;
        end
      end
      S_REL: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Storage array write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wp] <= bus.wr_data;
    end
  end

  // Registered read: the popped byte lands directly in the Din holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_din <= 8'h00;
    end else if (w_pop) begin
      r_din <= r_mem[r_rp];
    end
  end

  // Pointers and occupancy count; simultaneous write and pop leave the count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      case ({w_wr_acc, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic r_overflow;

  // Sticky flag for writes refused while full; setting wins over clearing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (bus.wr_en && w_full) begin
      r_overflow <= 1'b1;
    end else if (bus.ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign bus.overflow = r_overflow;
`endif

  assign bus.full  = w_full;
  assign bus.empty = w_empty;
  assign bus.level = r_cnt;
  assign bus.busy  = (r_state != S_IDLE);
  assign bus.Tx_en = w_tx_en;
  assign bus.Din   = r_din;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo. A cycle table covers the
// basic handshake; a behavioural UART model drives Tx_done for the burst,
// overflow, wrap, stale-Tx_done and reset-mid-frame sequences.
// Overflow checks are compiled in when UART_TX_FIFO_OVF_EN is defined.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- UART model ----------------
  bit        model_en = 1'b0;
  bit        m_stall  = 1'b0;
  int        m_frame  = 4;
  int        m_hold   = 1;
  int        m_phase  = 0;
  int        m_cnt    = 0;
  bit        m_armed  = 1'b1;
  logic      m_done   = 1'b0;
  logic      tbl_done = 1'b0;
  logic [7:0] rx [$];
  logic [7:0] exp_q [$];

  assign bus.Tx_done = model_en ? m_done : tbl_done;

  // Accepts one byte per Tx_en request, raises Tx_done after m_frame cycles
  // and holds it for m_hold cycles.
  always @(negedge clk) begin
    if (!model_en || rst) begin
      m_phase = 0;
      m_cnt   = 0;
      m_armed = 1'b1;
      m_done  = 1'b0;
    end else begin
      if (!bus.Tx_en) m_armed = 1'b1;
      case (m_phase)
        0: if (bus.Tx_en && m_armed) begin
             rx.push_back(bus.Din);
             $display("uart rx byte %02h (t=%0t)", bus.Din, $time);
             m_armed = 1'b0;
             m_phase = 1;
             m_cnt   = 0;
           end
        1: if (!m_stall) begin
             m_cnt++;
             if (m_cnt >= m_frame) begin
               m_done  = 1'b1;
               m_phase = 2;
               m_cnt   = 0;
             end
           end
        2: begin
             m_cnt++;
             if (m_cnt >= m_hold) begin
               m_done  = 1'b0;
               m_phase = 0;
             end
           end
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- per-cycle monitor ----------------
  bit        mon_en    = 1'b0;
  int        wr_acc    = 0;
  int        rises     = 0;
  int        peak      = 0;
  bit        full_seen = 1'b0;
  logic      prev_tx_en = 1'b0;
  logic [7:0] prev_din  = 8'h00;

  // Level must equal accepted writes minus pops (each pop raises Tx_en);
  // Din must not move while Tx_en stays high.
  always @(posedge clk) begin
    #1;
    if (bus.Tx_en && !prev_tx_en) rises++;
    if (mon_en) begin
      check("level_track", 32'(bus.level), 32'(wr_acc - rises));
      if (prev_tx_en && bus.Tx_en) check("din_stable", 32'(bus.Din), 32'(prev_din));
      if (bus.full) full_seen = 1'b1;
      if (int'(bus.level) > peak) peak = int'(bus.level);
    end
    prev_tx_en = bus.Tx_en;
    prev_din   = bus.Din;
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    wr_acc = 0;
    rises  = 0;
    peak   = 0;
    full_seen = 1'b0;
    rx.delete();
    exp_q.delete();
  endtask

  task automatic wr(input logic [7:0] d, input bit acc);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    @(posedge clk);
    if (acc) begin
      wr_acc++;
      exp_q.push_back(d);
    end
    $display("write %02h expect_accept=%0d (t=%0t)", d, acc, $time);
  endtask

  task automatic idle_wr();
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_rx(input string nm, input int n, input int budget);
    int cyc;
    cyc = 0;
    while (rx.size() < n && cyc < budget) begin
      @(posedge clk);
      cyc++;
    end
    check({nm, "_rx_timeout"}, 32'(rx.size() >= n), 32'd1);
  endtask

  task automatic cmp_rx(input string nm);
    check({nm, "_rx_count"}, 32'(rx.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx.size(); i++)
      check($sformatf("%s_rx_byte%0d", nm, i), 32'(rx[i]), 32'(exp_q[i]));
  endtask

  task automatic check_idle(input string nm);
    check({nm, "_idle"}, {bus.empty, bus.busy, bus.Tx_en, bus.full, bus.level},
          {1'b1, 1'b0, 1'b0, 1'b0, 5'd0});
  endtask

  // ---------------- cycle table ----------------
  typedef struct packed {
    logic       wr;
    logic [7:0] d;
    logic       done;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       busy;
    logic       tx_en;
    logic [7:0] din;
  } vec_t;

  vec_t tv [15];

  initial begin
    #(500000);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            wr    d      done  full  empty level  busy  tx_en din
    tv[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'h00};
    tv[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 8'hA5};
    tv[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 8'hA5};
    tv[3]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 8'hA5};
    tv[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 8'hA5};
    tv[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'hA5};
    tv[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 8'h5A};
    tv[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 8'h5A};
    tv[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 8'h5A};
    tv[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 8'h5A};
    tv[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 8'h5A};
    tv[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 8'h5A};
    tv[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 8'h5A};
    tv[13] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'h5A};
    tv[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 8'h3C};

    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
`ifdef UART_TX_FIFO_OVF_EN
    bus.ovf_clr = 1'b0;
`endif

    // Reset values.
    do_reset();
    #1;
    check("reset_state", {bus.full, bus.empty, bus.level, bus.busy, bus.Tx_en, bus.Din},
          {1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00});
`ifdef UART_TX_FIFO_OVF_EN
    check("reset_overflow", 32'(bus.overflow), 32'd0);
`endif

    // Cycle table: single byte, stale Tx_done in REL/START/IDLE.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      bus.wr_en   = tv[i].wr;
      bus.wr_data = tv[i].d;
      tbl_done    = tv[i].done;
      @(posedge clk);
      #1;
      $display("vec%0d wr=%0d d=%02h done=%0d -> tx_en=%0d din=%02h level=%0d",
               i, tv[i].wr, tv[i].d, tv[i].done, bus.Tx_en, bus.Din, bus.level);
      check($sformatf("vec%0d", i),
            {15'd0, bus.full, bus.empty, bus.level, bus.busy, bus.Tx_en, bus.Din},
            {15'd0, tv[i].full, tv[i].empty, tv[i].level, tv[i].busy, tv[i].tx_en, tv[i].din});
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
    tbl_done  = 1'b0;

    // Burst 01..10: one byte in flight, level peaks at 15, never full.
    model_en = 1'b1;
    m_stall  = 1'b0;
    m_frame  = 30;
    m_hold   = 1;
    do_reset();
    mon_en = 1'b1;
    for (int i = 1; i <= 16; i++) wr(8'(i), 1'b1);
    idle_wr();
    wait_rx("burst", 16, 2000);
    repeat (40) @(negedge clk);
    cmp_rx("burst");
    check("burst_peak", 32'(peak), 32'd15);
    check("burst_full_seen", 32'(full_seen), 32'd0);
    check_idle("burst");

    // Overflow: 17 accepted, 18th dropped.
    mon_en = 1'b0;
    m_stall = 1'b1;
    m_frame = 4;
    do_reset();
    mon_en = 1'b1;
    for (int i = 0; i < 17; i++) wr(8'h20 + 8'(i), 1'b1);
    #1;
    check("ovf_full_after17", 32'(bus.full), 32'd1);
`ifdef UART_TX_FIFO_OVF_EN
    check("ovf_flag_before18", 32'(bus.overflow), 32'd0);
`endif
    wr(8'h31, 1'b0);
    #1;
    check("ovf_level_after18", 32'(bus.level), 32'd16);
`ifdef UART_TX_FIFO_OVF_EN
    check("ovf_flag_after18", 32'(bus.overflow), 32'd1);
    @(negedge clk);
    bus.wr_data = 8'h32;
    bus.ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    check("ovf_set_beats_clr", 32'(bus.overflow), 32'd1);
    @(negedge clk);
    bus.wr_en = 1'b0;
    @(posedge clk);
    #1;
    check("ovf_cleared", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    bus.ovf_clr = 1'b0;
`endif
    idle_wr();
    m_stall = 1'b0;
    wait_rx("ovf", 17, 2000);
    repeat (20) @(negedge clk);
    cmp_rx("ovf");
    check_idle("ovf");

    // Wrap: fill 16 queued + 1 in flight, drain 10, write 10 more while popping.
    mon_en  = 1'b0;
    m_stall = 1'b1;
    do_reset();
    mon_en = 1'b1;
    for (int i = 0; i < 17; i++) wr(8'h40 + 8'(i), 1'b1);
    idle_wr();
    repeat (3) @(negedge clk);
    m_stall = 1'b0;
    wait_rx("wrap_drain", 11, 2000);
    for (int i = 0; i < 10; i++) wr(8'h51 + 8'(i), 1'b1);
    idle_wr();
    wait_rx("wrap", 27, 2000);
    repeat (20) @(negedge clk);
    cmp_rx("wrap");
    check_idle("wrap");

    // Stale Tx_done held 6 cycles after each frame.
    mon_en = 1'b0;
    m_hold = 6;
    do_reset();
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) wr(8'h61 + 8'(i), 1'b1);
    idle_wr();
    wait_rx("stale", 3, 500);
    repeat (60) @(negedge clk);
    cmp_rx("stale");
    check_idle("stale");

    // Reset while in WAIT with 5 bytes queued.
    mon_en  = 1'b0;
    m_hold  = 1;
    m_stall = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) wr(8'h71 + 8'(i), 1'b1);
    idle_wr();
    repeat (3) @(negedge clk);
    check("midrst_pre", {bus.busy, bus.Tx_en, bus.level}, {1'b1, 1'b1, 5'd5});
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_post", {bus.full, bus.empty, bus.level, bus.busy, bus.Tx_en, bus.Din},
          {1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00});
    @(negedge clk);
    rst   = 1'b0;
    rises = 0;
    rx.delete();
    m_stall = 1'b0;
    repeat (100) @(negedge clk);
    check("midrst_no_tx", 32'(rises), 32'd0);
    check("midrst_no_rx", 32'(rx.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
